// File: rtl/lpif_slave_quarter_rate_adapter.sv
// Slave-side x4 quarter-rate LPIF adapter: splits each 308-bit link word into four
// full-rate slices downstream and gathers four upstream slices into one link word.
module lpif_slave_quarter_rate_adapter #(
    parameter int SLICE_W   = 77,
    parameter int NUM_SLICE = 4
) (
    input  logic                         clk_wr,
    input  logic                         rst_wr_n,
    input  logic [SLICE_W*NUM_SLICE-1:0] rxfifo_downstream_data,
    input  logic                         rxfifo_downstream_vld,
    output logic                         rxfifo_downstream_rdy,
    output logic [3:0]                   dstrm_state,
    output logic [1:0]                   dstrm_protid,
    output logic [63:0]                  dstrm_data,
    output logic                         dstrm_dvalid,
    output logic [3:0]                   dstrm_crc,
    output logic                         dstrm_crc_valid,
    output logic                         dstrm_valid,
    output logic                         dstrm_push,
    input  logic [3:0]                   ustrm_state,
    input  logic [1:0]                   ustrm_protid,
    input  logic [63:0]                  ustrm_data,
    input  logic                         ustrm_dvalid,
    input  logic [3:0]                   ustrm_crc,
    input  logic                         ustrm_crc_valid,
    input  logic                         ustrm_valid,
    input  logic                         ustrm_push,
    input  logic                         ustrm_align,
    output logic [SLICE_W*NUM_SLICE-1:0] txfifo_upstream_data,
    output logic                         txfifo_upstream_vld,
    output logic                         gather_drop
);
    localparam int WORD_W = SLICE_W * NUM_SLICE;
    localparam int CW     = $clog2(NUM_SLICE);
    localparam logic [CW-1:0] LAST = CW'(NUM_SLICE - 1);

    // ---------------- downstream: word -> 4 slices ----------------
    logic [WORD_W-1:0]  dbuf;
    logic               busy;
    logic [CW-1:0]      dcnt;
    logic [SLICE_W-1:0] dslice;
    logic               dhs;

    // Ready on the last slice lets the next word follow with no bubble.
    assign rxfifo_downstream_rdy = rst_wr_n & (~busy | (dcnt == LAST));
    assign dhs = rxfifo_downstream_vld & rxfifo_downstream_rdy;

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            dbuf <= '0;
            busy <= 1'b0;
            dcnt <= '0;
        end else if (dhs) begin
            dbuf <= rxfifo_downstream_data;
            busy <= 1'b1;
            dcnt <= '0;
        end else if (busy) begin
            dcnt <= dcnt + CW'(1);
            if (dcnt == LAST) busy <= 1'b0;
        end
    end

    always_comb begin
        dslice = '0;
        if (busy) dslice = dbuf[int'(dcnt)*SLICE_W +: SLICE_W];
    end

    assign dstrm_push      = busy;
    assign dstrm_state     = dslice[3:0];
    assign dstrm_protid    = dslice[5:4];
    assign dstrm_data      = dslice[69:6];
    assign dstrm_dvalid    = dslice[70];
    assign dstrm_crc       = dslice[74:71];
    assign dstrm_crc_valid = dslice[75];
    assign dstrm_valid     = dslice[76];

    // ---------------- upstream: 4 slices -> word ----------------
    logic [SLICE_W-1:0]             uslice;
    logic [(NUM_SLICE-1)*SLICE_W-1:0] shadow;
    logic [CW-1:0]                  ucnt;

    assign uslice = {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
                     ustrm_data, ustrm_protid, ustrm_state};

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            shadow               <= '0;
            ucnt                 <= '0;
            txfifo_upstream_data <= '0;
            txfifo_upstream_vld  <= 1'b0;
            gather_drop          <= 1'b0;
        end else begin
            txfifo_upstream_vld <= 1'b0;
            gather_drop         <= 1'b0;
            // Align overrides a completing push: the slice restarts the gather.
            if (ustrm_align) begin
                gather_drop <= (ucnt != '0);
                if (ustrm_push) begin
                    shadow[SLICE_W-1:0] <= uslice;
                    ucnt                <= CW'(1);
                end else begin
                    ucnt <= '0;
                end
            end else if (ustrm_push) begin
                if (ucnt == LAST) begin
                    txfifo_upstream_data <= {uslice, shadow};
                    txfifo_upstream_vld  <= 1'b1;
                    ucnt                 <= '0;
                end else begin
                    shadow[int'(ucnt)*SLICE_W +: SLICE_W] <= uslice;
                    ucnt <= ucnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_lpif_slave_quarter_rate_adapter.sv
// Scoreboard bench: a negedge monitor checks DUT outputs against queues of expected
// slices/words built from the observed inputs, then updates the reference model.
module tb_lpif_slave_quarter_rate_adapter;
    localparam int SW = 77;
    localparam int NS = 4;
    localparam int WW = SW * NS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [WW-1:0] rx_data = '0;
    logic          rx_vld = 1'b0;
    logic          rx_rdy;
    logic [3:0]    dstrm_state;
    logic [1:0]    dstrm_protid;
    logic [63:0]   dstrm_data;
    logic          dstrm_dvalid;
    logic [3:0]    dstrm_crc;
    logic          dstrm_crc_valid;
    logic          dstrm_valid;
    logic          dstrm_push;
    logic [3:0]    ustrm_state;
    logic [1:0]    ustrm_protid;
    logic [63:0]   ustrm_data;
    logic          ustrm_dvalid;
    logic [3:0]    ustrm_crc;
    logic          ustrm_crc_valid;
    logic          ustrm_valid;
    logic          ustrm_push;
    logic          ustrm_align;
    logic [WW-1:0] tx_data;
    logic          tx_vld;
    logic          gather_drop;

    // bench-driven upstream stimulus, or loopback from the downstream outputs
    logic          loop = 1'b0;
    logic [3:0]    d_state = '0;
    logic [1:0]    d_protid = '0;
    logic [63:0]   d_data = '0;
    logic          d_dvalid = 1'b0;
    logic [3:0]    d_crc = '0;
    logic          d_crcv = 1'b0;
    logic          d_valid = 1'b0;
    logic          d_push = 1'b0;
    logic          d_align = 1'b0;

    always_comb begin
        if (loop) begin
            ustrm_state = dstrm_state; ustrm_protid = dstrm_protid; ustrm_data = dstrm_data;
            ustrm_dvalid = dstrm_dvalid; ustrm_crc = dstrm_crc; ustrm_crc_valid = dstrm_crc_valid;
            ustrm_valid = dstrm_valid; ustrm_push = dstrm_push; ustrm_align = 1'b0;
        end else begin
            ustrm_state = d_state; ustrm_protid = d_protid; ustrm_data = d_data;
            ustrm_dvalid = d_dvalid; ustrm_crc = d_crc; ustrm_crc_valid = d_crcv;
            ustrm_valid = d_valid; ustrm_push = d_push; ustrm_align = d_align;
        end
    end

    lpif_slave_quarter_rate_adapter #(.SLICE_W(SW), .NUM_SLICE(NS)) dut (
        .clk_wr(clk), .rst_wr_n(rst_n),
        .rxfifo_downstream_data(rx_data), .rxfifo_downstream_vld(rx_vld),
        .rxfifo_downstream_rdy(rx_rdy),
        .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
        .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
        .dstrm_valid(dstrm_valid), .dstrm_push(dstrm_push),
        .ustrm_state(ustrm_state), .ustrm_protid(ustrm_protid), .ustrm_data(ustrm_data),
        .ustrm_dvalid(ustrm_dvalid), .ustrm_crc(ustrm_crc), .ustrm_crc_valid(ustrm_crc_valid),
        .ustrm_valid(ustrm_valid), .ustrm_push(ustrm_push), .ustrm_align(ustrm_align),
        .txfifo_upstream_data(tx_data), .txfifo_upstream_vld(tx_vld),
        .gather_drop(gather_drop)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] fld(input logic [WW-1:0] w, input int k, input int off, input int wd);
        logic [WW-1:0] t;
        t = w >> (SW * k + off);
        return 64'(t) & ((64'd1 << wd) - 64'd1);
    endfunction

    function automatic logic [SW-1:0] mk_slice(input logic [3:0] st, input logic [1:0] pid,
            input logic [63:0] dat, input logic dv, input logic [3:0] crc,
            input logic cv, input logic v);
        logic [SW-1:0] s;
        s = SW'(st);
        s = s | (SW'(pid) << 4);
        s = s | (SW'(dat) << 6);
        s = s | (SW'(dv) << 70);
        s = s | (SW'(crc) << 71);
        s = s | (SW'(cv) << 75);
        s = s | (SW'(v) << 76);
        return s;
    endfunction

    typedef struct { logic [WW-1:0] w; int k; } ds_t;
    ds_t           dq[$];
    logic [WW-1:0] uq[$];
    logic [WW-1:0] lbq[$];
    logic [SW-1:0] part[$];
    int            dropq[$];
    logic [WW-1:0] last_word = '0;
    logic          armed = 1'b0;

    always @(negedge clk) begin
        if (armed) begin
            ds_t e;
            logic [WW-1:0] w;
            // ---- check phase ----
            chk("ds_rdy", WW'(rx_rdy), WW'(rst_n && dq.size() <= 1));
            chk("ds_push", WW'(dstrm_push), WW'(dq.size() > 0));
            if (dstrm_push && dq.size() > 0) begin
                e = dq.pop_front();
                chk("ds_state",  WW'(dstrm_state),     WW'(fld(e.w, e.k, 0, 4)));
                chk("ds_protid", WW'(dstrm_protid),    WW'(fld(e.w, e.k, 4, 2)));
                chk("ds_data",   WW'(dstrm_data),      WW'(fld(e.w, e.k, 6, 64)));
                chk("ds_dvalid", WW'(dstrm_dvalid),    WW'(fld(e.w, e.k, 70, 1)));
                chk("ds_crc",    WW'(dstrm_crc),       WW'(fld(e.w, e.k, 71, 4)));
                chk("ds_crcv",   WW'(dstrm_crc_valid), WW'(fld(e.w, e.k, 75, 1)));
                chk("ds_valid",  WW'(dstrm_valid),     WW'(fld(e.w, e.k, 76, 1)));
            end else if (!dstrm_push) begin
                chk("ds_idle_zero", WW'({dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
                                         dstrm_crc, dstrm_crc_valid, dstrm_valid}), '0);
            end
            chk("us_vld", WW'(tx_vld), WW'(uq.size() > 0));
            if (tx_vld && uq.size() > 0) last_word = uq.pop_front();
            chk("us_data", tx_data, last_word);
            chk("us_drop", WW'(gather_drop), WW'(dropq.size() > 0));
            if (dropq.size() > 0) void'(dropq.pop_front());
            if (tx_vld && loop) begin
                if (lbq.size() > 0) chk("loopback", tx_data, lbq.pop_front());
                else chk("loopback_extra", WW'(1), WW'(0));
            end
            // ---- model update ----
            if (!rst_n) begin
                dq.delete(); uq.delete(); lbq.delete(); part.delete(); dropq.delete();
                last_word = '0;
            end else begin
                if (rx_vld && rx_rdy) begin
                    for (int k = 0; k < NS; k++) begin
                        e.w = rx_data; e.k = k;
                        dq.push_back(e);
                    end
                    if (loop) lbq.push_back(rx_data);
                end
                if (ustrm_align) begin
                    if (part.size() != 0) dropq.push_back(1);
                    part.delete();
                    if (ustrm_push)
                        part.push_back(mk_slice(ustrm_state, ustrm_protid, ustrm_data,
                            ustrm_dvalid, ustrm_crc, ustrm_crc_valid, ustrm_valid));
                end else if (ustrm_push) begin
                    part.push_back(mk_slice(ustrm_state, ustrm_protid, ustrm_data,
                        ustrm_dvalid, ustrm_crc, ustrm_crc_valid, ustrm_valid));
                    if (part.size() == NS) begin
                        w = '0;
                        for (int k = 0; k < NS; k++) w = w | (WW'(part[k]) << (SW * k));
                        uq.push_back(w);
                        part.delete();
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        int n;
        rx_data = w;
        rx_vld  = 1'b1;
        n = 0;
        while (!rx_rdy && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_cmp++; n_err++;
            $display("FAIL rdy_timeout: got rdy=0 for 20 cycles, expected 1");
        end
        tick();
        rx_vld = 1'b0;
    endtask

    task automatic upush(input logic [63:0] dat, input logic align);
        d_state = 4'($urandom); d_protid = 2'($urandom); d_data = dat;
        d_dvalid = 1'($urandom); d_crc = 4'($urandom); d_crcv = 1'($urandom);
        d_valid = 1'b1; d_push = 1'b1; d_align = align;
        tick();
        d_push = 1'b0; d_align = 1'b0;
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < 10; i++) w = (w << 32) | WW'($urandom);
        return w;
    endfunction

    function automatic logic [WW-1:0] pattern_word(input int base);
        logic [WW-1:0] w;
        w = '0;
        for (int k = 0; k < NS; k++)
            w = w | (WW'(mk_slice(4'(k), 2'(k), 64'(base + k), 1'b1, 4'(k + 5), 1'b1, 1'b1)) << (SW * k));
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 armed = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // single word, then back-to-back pair
        send_word(pattern_word(32'hA0));
        repeat (6) tick();
        send_word(pattern_word(32'hB0));
        send_word(pattern_word(32'hC0));
        repeat (8) tick();

        // upstream gather with gaps 0, 3, 1
        upush(64'd1, 1'b0);
        upush(64'd2, 1'b0);
        repeat (3) tick();
        upush(64'd3, 1'b0);
        tick();
        upush(64'd4, 1'b0);
        repeat (3) tick();

        // align mid-word discards the partial gather
        upush(64'd7, 1'b0);
        upush(64'd8, 1'b0);
        upush(64'd9, 1'b1);
        upush(64'd10, 1'b0);
        upush(64'd11, 1'b0);
        upush(64'd12, 1'b0);
        repeat (3) tick();

        // reset in the middle of both paths
        upush(64'd20, 1'b0);
        upush(64'd21, 1'b0);
        send_word(pattern_word(32'hD0));
        tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send_word(pattern_word(32'hE0));
        for (int i = 0; i < 4; i++) upush(64'(32'h30 + i), 1'b0);
        repeat (6) tick();

        // random upstream traffic with occasional aligns
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) tick();
            else upush({$urandom, $urandom}, $urandom_range(0, 7) == 0);
        end
        d_align = 1'b1;
        tick();
        d_align = 1'b0;
        repeat (2) tick();

        // random loopback
        loop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            send_word(rand_word());
        end
        repeat (12) tick();
        chk("lb_drained", WW'(lbq.size()), '0);
        loop = 1'b0;
        repeat (3) tick();

        chk("ds_drained", WW'(dq.size()), '0);
        chk("us_drained", WW'(uq.size()), '0);
        chk("drop_drained", WW'(dropq.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
